// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative RV32M multiply/divide unit, one bit per cycle plus a sign-fixup cycle
// Divider datapath is compiled in only when MULDIV_DIV_EN is defined.
module muldiv_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  funct3,
  input  logic [31:0] srcA,
  input  logic [31:0] srcB,
  output logic        busy,
  output logic        done,
  output logic [31:0] result
);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t      state, state_next;
  logic [2:0]  op;
  logic [63:0] acc;
  logic [31:0] operand;
  logic [4:0]  count;
  logic        res_neg;

  logic        a_signed, b_signed, a_neg, b_neg;
  logic [31:0] mag_a, mag_b;
  logic        skip_calc, load_neg;
  logic [63:0] load_acc;
  logic [31:0] load_operand;
  logic [32:0] mul_sum;
  logic [63:0] mul_step, acc_step, prod_fixed;
  logic [31:0] fix_value;
`ifdef MULDIV_DIV_EN
  logic [32:0] div_shift;
  logic        div_ge;
  logic [31:0] div_diff, word_sel, div_fixed;
  logic [63:0] div_step;
`endif

  // Operand capture: magnitudes, result sign and the initial accumulator.
  always_comb begin
    a_signed = (funct3 == 3'b001) || (funct3 == 3'b010);
    b_signed = (funct3 == 3'b001);
`ifdef MULDIV_DIV_EN
    if (funct3[2] && !funct3[0]) begin
      a_signed = 1'b1;
      b_signed = 1'b1;
    end
`endif
    a_neg = a_signed & srcA[31];
    b_neg = b_signed & srcB[31];
    mag_a = a_neg ? -srcA : srcA;
    mag_b = b_neg ? -srcB : srcB;
`ifdef MULDIV_DIV_EN
    skip_calc    = funct3[2] && (srcB == 32'd0);
    load_operand = funct3[2] ? mag_b : mag_a;
    if (!funct3[2]) begin
      load_neg = a_neg ^ b_neg;
      load_acc = {32'd0, mag_b};
    end else if (skip_calc) begin
      // Divide by zero: remainder word = dividend, quotient word = all ones.
      load_neg = 1'b0;
      load_acc = {srcA, 32'hFFFF_FFFF};
    end else begin
      load_neg = funct3[1] ? a_neg : (a_neg ^ b_neg);
      load_acc = {32'd0, mag_a};
    end
`else
    skip_calc    = funct3[2];
    load_neg     = a_neg ^ b_neg;
    load_acc     = {32'd0, mag_b};
    load_operand = mag_a;
`endif
  end

  // One iteration: shift-add for multiply, restoring step for divide.
  always_comb begin
    mul_sum  = {1'b0, acc[63:32]} + {1'b0, operand};
    mul_step = acc[0] ? {mul_sum, acc[31:1]} : {1'b0, acc[63:1]};
    acc_step = mul_step;
`ifdef MULDIV_DIV_EN
    div_shift = {acc[63:32], acc[31]};
    div_ge    = div_shift >= {1'b0, operand};
    div_diff  = div_shift[31:0] - operand;
    div_step  = div_ge ? {div_diff, acc[30:0], 1'b1} : {div_shift[31:0], acc[30:0], 1'b0};
    if (op[2]) acc_step = div_step;
`endif
  end

  always_comb begin
    prod_fixed = res_neg ? -acc : acc;
    fix_value  = (op[1:0] == 2'b00) ? prod_fixed[31:0] : prod_fixed[63:32];
`ifdef MULDIV_DIV_EN
    word_sel  = op[1] ? acc[63:32] : acc[31:0];
    div_fixed = res_neg ? -word_sel : word_sel;
    if (op[2]) fix_value = div_fixed;
`else
    if (op[2]) fix_value = 32'd0;
`endif
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (start) state_next = skip_calc ? FIX : CALC;
      CALC: if (count == 5'd0) state_next = FIX;
      FIX:  state_next = DONE;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      op      <= 3'd0;
      acc     <= 64'd0;
      operand <= 32'd0;
      count   <= 5'd0;
      res_neg <= 1'b0;
      result  <= 32'd0;
    end else begin
      case (state)
        IDLE: if (start) begin
          op      <= funct3;
          acc     <= load_acc;
          operand <= load_operand;
          res_neg <= load_neg;
          count   <= 5'd31;
        end
        CALC: begin
          acc   <= acc_step;
          count <= count - 5'd1;
        end
        FIX: result <= fix_value;
        default: ;
      endcase
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - scoreboard bench for muldiv_unit; expectations follow MULDIV_DIV_EN
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  funct3 = 3'd0;
  logic [31:0] srcA = 32'd0;
  logic [31:0] srcB = 32'd0;
  logic        busy, done;
  logic [31:0] result;

  typedef struct {
    string       name;
    logic [31:0] res;
    int          lat;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   passes = 0;
  int   cyc = 0;
  int   start_cyc = 0;
  int   busy_cnt = 0;
  logic busy_q = 1'b0;

  muldiv_unit dut (
    .clk(clk), .reset(reset), .start(start), .funct3(funct3),
    .srcA(srcA), .srcB(srcB), .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  // Monitor: latency counts cycles from the accepting edge to the done cycle inclusive.
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (busy && !busy_q) begin
      start_cyc = cyc;
      busy_cnt  = 0;
    end
    if (busy) busy_cnt++;
    busy_q = busy;
    if (done) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 32'(done), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check({e.name, "_result"}, result, e.res);
        check({e.name, "_latency"}, 32'(cyc - start_cyc + 1), 32'(e.lat));
        check({e.name, "_busy_cycles"}, 32'(busy_cnt), 32'(e.lat));
      end
    end
  end

  task automatic issue(input string name, input logic [2:0] f, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] r, input int lat, input bit expect_done);
    int n = 0;
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (busy) check({name, "_idle_wait"}, 32'(busy), 32'd0);
    funct3 = f;
    srcA   = a;
    srcB   = b;
    start  = 1'b1;
    if (expect_done) exp_q.push_back('{name, r, lat});
    @(negedge clk);
    start  = 1'b0;
    srcA   = 32'hDEAD_BEEF;
    srcB   = 32'h0;
    funct3 = ~f;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      check({name, "_timeout"}, 32'(exp_q.size()), 32'd0);
      exp_q.delete();
    end
  endtask

  task automatic run(input string name, input logic [2:0] f, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] r, input int lat);
    issue(name, f, a, b, r, lat, 1'b1);
    drain(name);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_result", result, 32'd0);
    reset = 1'b1;
    @(negedge clk);

    run("mul_neg",    3'b000, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 34);
    run("mulh_min",   3'b001, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 34);
    run("mulhu_max",  3'b011, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 34);
    run("mulhsu_max", 3'b010, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 34);
`ifdef MULDIV_DIV_EN
    run("div_neg",    3'b100, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 34);
    run("rem_neg",    3'b110, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 34);
    run("divu",       3'b101, 32'd100,        32'd7,         32'd14,        34);
    run("remu",       3'b111, 32'd100,        32'd7,         32'd2,         34);
    run("div_zero",   3'b100, 32'd5,          32'd0,         32'hFFFF_FFFF, 2);
    run("remu_zero",  3'b111, 32'd5,          32'd0,         32'd5,         2);
    run("div_ovf",    3'b100, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 34);
    run("rem_ovf",    3'b110, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         34);
`else
    run("divu_off",   3'b101, 32'd100,        32'd7,         32'd0,         2);
    run("rem_off",    3'b110, 32'hFFFF_FFF9,  32'd2,         32'd0,         2);
`endif
    run("mul_small",  3'b000, 32'd7,          32'd6,         32'd42,        34);

    issue("mul_ignore", 3'b000, 32'd9, 32'd11, 32'd99, 34, 1'b1);
    repeat (3) @(negedge clk);
    funct3 = 3'b000;
    srcA   = 32'd100;
    srcB   = 32'd100;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    drain("mul_ignore");

    issue("mul_abort", 3'b000, 32'd3, 32'd5, 32'd15, 34, 1'b0);
    repeat (8) @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_result", result, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (40) @(negedge clk);

    run("mul_after_reset", 3'b000, 32'd7, 32'd6, 32'd42, 34);
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
